// File: rtl/ps2_game_input.sv
// PS/2 keyboard receiver plus scan-code decoder producing game controls.
// Define FIRE_AUTOREPEAT_EN to repeat fire pulses while the fire key is held.
module ps2_game_input #(
  parameter int TIMEOUT_CYCLES     = 50000,
  parameter int FIRE_REPEAT_CYCLES = 2500000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       pause,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       rx_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_prev;
  logic          fall, bit_in;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [TW-1:0] idle_cnt;

  dec_state_t state, state_n;
  logic ev, ev_ext, ev_brk;
  logic hit_la, hit_lb, hit_ra, hit_rb, hit_fire, hit_pause;
  logic left_a, left_b, right_a, right_b, fire_held, pause_held;
  logic fire_press, rep_fire;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // shreg collects data LSB first then parity; after 9 shifts parity sits in bit 8
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      rx_error  <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!bit_in) bit_cnt <= 4'd1;
        end else if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (bit_in && (^shreg)) begin
            key_code  <= shreg[7:0];
            key_valid <= 1'b1;
          end else begin
            rx_error <= 1'b1;
          end
        end else begin
          shreg   <= {bit_in, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
          rx_error <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    ev      = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (key_valid) begin
      case (state)
        IDLE: begin
          if (key_code == 8'hE0)      state_n = EXT;
          else if (key_code == 8'hF0) state_n = BRK;
          else                        ev = 1'b1;
        end
        EXT: begin
          if (key_code == 8'hF0)      state_n = EXT_BRK;
          else if (key_code == 8'hE0) state_n = EXT;
          else begin
            ev = 1'b1; ev_ext = 1'b1; state_n = IDLE;
          end
        end
        BRK: begin
          if (key_code == 8'hE0)      state_n = EXT;
          else if (key_code == 8'hF0) state_n = BRK;
          else begin
            ev = 1'b1; ev_brk = 1'b1; state_n = IDLE;
          end
        end
        EXT_BRK: begin
          if (key_code == 8'hE0)      state_n = EXT;
          else if (key_code == 8'hF0) state_n = BRK;
          else begin
            ev = 1'b1; ev_ext = 1'b1; ev_brk = 1'b1; state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign hit_la     = ev && !ev_ext && (key_code == 8'h1C);
  assign hit_lb     = ev &&  ev_ext && (key_code == 8'h6B);
  assign hit_ra     = ev && !ev_ext && (key_code == 8'h23);
  assign hit_rb     = ev &&  ev_ext && (key_code == 8'h74);
  assign hit_fire   = ev && !ev_ext && (key_code == 8'h29);
  assign hit_pause  = ev && !ev_ext && (key_code == 8'h4D);
  assign fire_press = hit_fire && !ev_brk && !fire_held;

`ifdef FIRE_AUTOREPEAT_EN
  localparam int RW = $clog2(FIRE_REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_cnt;

  assign rep_fire = fire_held && !(hit_fire && ev_brk) &&
                    (rep_cnt == RW'(FIRE_REPEAT_CYCLES - 1));

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)                                         rep_cnt <= '0;
    else if (!fire_held || rep_fire || (hit_fire && ev_brk)) rep_cnt <= '0;
    else                                                 rep_cnt <= rep_cnt + 1'b1;
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^FIRE_REPEAT_CYCLES;
  assign rep_fire          = 1'b0;
`endif

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      left_a     <= 1'b0;
      left_b     <= 1'b0;
      right_a    <= 1'b0;
      right_b    <= 1'b0;
      fire_held  <= 1'b0;
      pause_held <= 1'b0;
      pause      <= 1'b0;
      fire       <= 1'b0;
    end else begin
      fire <= fire_press | rep_fire;
      if (hit_la)   left_a    <= !ev_brk;
      if (hit_lb)   left_b    <= !ev_brk;
      if (hit_ra)   right_a   <= !ev_brk;
      if (hit_rb)   right_b   <= !ev_brk;
      if (hit_fire) fire_held <= !ev_brk;
      if (hit_pause) begin
        if (!ev_brk && !pause_held) pause <= ~pause;
        pause_held <= !ev_brk;
      end
    end
  end

  assign move_left  =  (left_a | left_b) & ~(right_a | right_b);
  assign move_right = ~(left_a | left_b) &  (right_a | right_b);

endmodule

// File: tb/tb_ps2_game_input.sv
// Directed bench for ps2_game_input: bit-banged PS/2 frames, vector table plus corner sequences.
module tb_ps2_game_input;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       move_left, move_right, fire, pause, key_valid, rx_error;
  logic [7:0] key_code;

  always #5 clk = ~clk;

  ps2_game_input #(
    .TIMEOUT_CYCLES    (50000),
    .FIRE_REPEAT_CYCLES(100)
  ) dut (
    .iVGA_CLK  (clk),
    .iRST_n    (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .move_left (move_left),
    .move_right(move_right),
    .fire      (fire),
    .pause     (pause),
    .key_code  (key_code),
    .key_valid (key_valid),
    .rx_error  (rx_error)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned cyc = 0, kv_cnt = 0, err_cnt = 0, fire_cnt = 0;
  int unsigned kv_cyc = 0, ml_rise_cyc = 0, long_pulses = 0;
  logic kv_prev = 1'b0, err_prev = 1'b0, fire_prev = 1'b0, ml_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (key_valid) begin
      kv_cnt = kv_cnt + 1;
      kv_cyc = cyc;
    end
    if (rx_error) err_cnt = err_cnt + 1;
    if (fire) fire_cnt = fire_cnt + 1;
    if ((key_valid && kv_prev) || (rx_error && err_prev) || (fire && fire_prev))
      long_pulses = long_pulses + 1;
    if (move_left && !ml_prev) ml_rise_cyc = cyc;
    kv_prev   = key_valid;
    err_prev  = rx_error;
    fire_prev = fire;
    ml_prev   = move_left;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par);
    return {1'b1, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      wait_clk(2);
      ps2_clk = 1'b0;
      wait_clk(2);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b, 1'b0), 11);
    wait_clk(8);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic       ml, mr, pz;
    logic [7:0] code;
  } vec_t;

  vec_t vecs[18];

  int unsigned kv0, err0, f0;
  int unsigned fire_exp;
  logic [10:0] fr;

  initial begin
    vecs[0]  = '{8'h4D, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h4D};
    vecs[1]  = '{8'h4D, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b1, 8'h4D};
    vecs[2]  = '{8'hF0, 8'h4D, 8'h00, 2, 1'b0, 1'b0, 1'b1, 8'h4D};
    vecs[3]  = '{8'h4D, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h4D};
    vecs[4]  = '{8'hF0, 8'h4D, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'h4D};
    vecs[5]  = '{8'hE0, 8'h74, 8'h00, 2, 1'b0, 1'b1, 1'b0, 8'h74};
    vecs[6]  = '{8'h1C, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h1C};
    vecs[7]  = '{8'hF0, 8'h1C, 8'h00, 2, 1'b0, 1'b1, 1'b0, 8'h1C};
    vecs[8]  = '{8'hE0, 8'hF0, 8'h74, 3, 1'b0, 1'b0, 1'b0, 8'h74};
    vecs[9]  = '{8'hE0, 8'h6B, 8'h00, 2, 1'b1, 1'b0, 1'b0, 8'h6B};
    vecs[10] = '{8'h23, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h23};
    vecs[11] = '{8'hE0, 8'hF0, 8'h6B, 3, 1'b0, 1'b1, 1'b0, 8'h6B};
    vecs[12] = '{8'hF0, 8'h23, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'h23};
    vecs[13] = '{8'hE0, 8'h1C, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'h1C};
    vecs[14] = '{8'h5A, 8'h00, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h5A};
    vecs[15] = '{8'h1C, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'h1C};
    vecs[16] = '{8'hE0, 8'hF0, 8'h1C, 3, 1'b1, 1'b0, 1'b0, 8'h1C};
    vecs[17] = '{8'hF0, 8'h1C, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'h1C};

    // Reset values
    wait_clk(4);
    @(negedge clk);
    check("rst move_left", move_left, 1'b0);
    check("rst move_right", move_right, 1'b0);
    check("rst fire", fire, 1'b0);
    check("rst pause", pause, 1'b0);
    check("rst key_code", key_code, 8'h00);
    check("rst key_valid", key_valid, 1'b0);
    check("rst rx_error", rx_error, 1'b0);
    rst_n = 1'b1;
    wait_clk(4);

    // Single make: key_valid one cycle before move_left
    kv0 = kv_cnt;
    send_byte(8'h1C);
    @(negedge clk);
    check("1C key_valid count", kv_cnt - kv0, 1);
    check("1C key_code", key_code, 8'h1C);
    check("1C move_left", move_left, 1'b1);
    check("1C move latency", ml_rise_cyc - kv_cyc, 1);
    send_byte(8'hF0);
    send_byte(8'h1C);
    @(negedge clk);
    check("1C release move_left", move_left, 1'b0);

    // Bad parity
    kv0 = kv_cnt; err0 = err_cnt; f0 = fire_cnt;
    send_bits(frame(8'h29, 1'b1), 11);
    wait_clk(8);
    @(negedge clk);
    check("badpar rx_error", err_cnt - err0, 1);
    check("badpar key_valid", kv_cnt - kv0, 0);
    check("badpar fire", fire_cnt - f0, 0);

    // Stop bit low
    kv0 = kv_cnt; err0 = err_cnt;
    fr = frame(8'h1C, 1'b0);
    fr[10] = 1'b0;
    send_bits(fr, 11);
    wait_clk(8);
    @(negedge clk);
    check("badstop rx_error", err_cnt - err0, 1);
    check("badstop key_valid", kv_cnt - kv0, 0);
    check("badstop move_left", move_left, 1'b0);

    // Start bit sampled high is ignored
    kv0 = kv_cnt; err0 = err_cnt;
    send_bits(11'h7FF, 1);
    wait_clk(6);
    send_byte(8'h23);
    @(negedge clk);
    check("start1 rx_error", err_cnt - err0, 0);
    check("start1 key_valid", kv_cnt - kv0, 1);
    check("start1 key_code", key_code, 8'h23);
    check("start1 move_right", move_right, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h23);
    @(negedge clk);
    check("start1 release", move_right, 1'b0);

    // Mid-frame timeout: start + 4 data bits then silence
    kv0 = kv_cnt; err0 = err_cnt;
    send_bits(frame(8'h4D, 1'b0), 5);
    wait_clk(50020);
    @(negedge clk);
    check("timeout rx_error", err_cnt - err0, 1);
    check("timeout key_valid", kv_cnt - kv0, 0);

    // Vector table
    f0 = fire_cnt;
    foreach (vecs[i]) begin
      kv0 = kv_cnt; err0 = err_cnt;
      send_byte(vecs[i].b0);
      if (vecs[i].n > 1) send_byte(vecs[i].b1);
      if (vecs[i].n > 2) send_byte(vecs[i].b2);
      @(negedge clk);
      check($sformatf("vec%0d key_valid count", i), kv_cnt - kv0, vecs[i].n);
      check($sformatf("vec%0d rx_error count", i), err_cnt - err0, 0);
      check($sformatf("vec%0d move_left", i), move_left, vecs[i].ml);
      check($sformatf("vec%0d move_right", i), move_right, vecs[i].mr);
      check($sformatf("vec%0d pause", i), pause, vecs[i].pz);
      check($sformatf("vec%0d key_code", i), key_code, vecs[i].code);
    end
    check("table fire count", fire_cnt - f0, 0);

    // Fire: typematic repeat make does not pulse
    f0 = fire_cnt;
    send_byte(8'h29);
    @(negedge clk);
    check("fire make pulse", fire_cnt - f0, 1);
    send_byte(8'h29);
    @(negedge clk);
    check("fire repeat make", fire_cnt - f0, 1);
    send_byte(8'hF0);
    send_byte(8'h29);
    wait_clk(200);

    // Fire held ~350 clocks after first pulse, then released
    f0 = fire_cnt;
    send_byte(8'h29);
    wait_clk(242);
    send_byte(8'hF0);
    send_byte(8'h29);
    @(negedge clk);
`ifdef FIRE_AUTOREPEAT_EN
    fire_exp = 4;
`else
    fire_exp = 1;
`endif
    check("fire hold pulses", fire_cnt - f0, fire_exp);
    wait_clk(200);
    check("fire after release", fire_cnt - f0, fire_exp);
    check("pulse widths", long_pulses, 0);

    // Reset mid-frame
    send_byte(8'h4D);
    send_byte(8'h1C);
    @(negedge clk);
    check("prereset pause", pause, 1'b1);
    check("prereset move_left", move_left, 1'b1);
    kv0 = kv_cnt; err0 = err_cnt;
    send_bits(frame(8'h5A, 1'b0), 6);
    rst_n = 1'b0;
    wait_clk(3);
    @(negedge clk);
    check("midrst move_left", move_left, 1'b0);
    check("midrst move_right", move_right, 1'b0);
    check("midrst pause", pause, 1'b0);
    check("midrst fire", fire, 1'b0);
    check("midrst key_code", key_code, 8'h00);
    rst_n = 1'b1;
    wait_clk(10);
    @(negedge clk);
    check("midrst key_valid", kv_cnt - kv0, 0);
    check("midrst rx_error", err_cnt - err0, 0);
    send_byte(8'h23);
    @(negedge clk);
    check("postrst key_valid", kv_cnt - kv0, 1);
    check("postrst key_code", key_code, 8'h23);
    check("postrst move_right", move_right, 1'b1);
    check("postrst pause", pause, 1'b0);
    check("postrst rx_error", err_cnt - err0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
